// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and controller-state encodings.
package alu_pkg;

  // Opcode values as presented on the op port.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  // Controller states: waiting for work, iterating the multiplier, holding a result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// start loads the operands; done is high during the cycle whose closing
// edge completes the last of WIDTH iterations, with product valid alongside.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] acc_sum;

  // Partial-product accumulate for the current multiplier bit.
  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_sum;

  // Next-state: load on start, otherwise advance one iteration while busy.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  // Datapath and iteration-count registers; reset discards any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete on the accept edge; MUL iterates WIDTH cycles.
// Build option: define ALU_SEQ_MUL_EN to include the iterative multiplier;
// without it op 7 completes in one cycle with result 0 and err set.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry,
  output logic                 err
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;

  op_e                op_w;
  logic [2*WIDTH-1:0] a_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] alu_res;
  logic               alu_carry;
  logic               alu_err;

  assign op_w  = op_e'(op);
  assign a_ext = {{WIDTH{1'b0}}, a};

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Single-cycle operations evaluated directly from the port operands.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    sum       = {1'b0, a} + {1'b0, b};
    diff      = a - b;
    case (op_w)
      OP_ADD: begin
        alu_res   = {{(WIDTH-1){1'b0}}, sum};
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = {{WIDTH{1'b0}}, diff};
        alu_carry = (a < b);
      end
      OP_AND: alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, a ^ b};
      OP_SHL: alu_res = a_ext << b;
      OP_SHR: alu_res = {{WIDTH{1'b0}}, a >> b};
      OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
        alu_err = 1'b1;
`endif
      end
      default: alu_res = '0;
    endcase
  end

  // Controller next-state and result/flag capture.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          if (op_w == OP_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else
`endif
          begin
            state_d  = ST_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
            err_d    = alu_err;
          end
        end
      end
      ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          state_d  = ST_DONE;
          result_d = mul_product;
          zero_d   = (mul_product == '0);
          carry_d  = 1'b0;
          err_d    = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything and returns to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH = 3. Expected values come from an
// arithmetic reference model; ALU_SEQ_MUL_EN selects the multiplier expectations.
module tb_alu_seq;

  localparam int W = 3;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           zero;
  logic           carry;
  logic           err;

  int checks = 0;
  int errors = 0;

  int last_res;
  int last_zero;
  int last_carry;
  int last_err;
  int last_lat;

  typedef struct {
    int res;
    int z;
    int c;
    int e;
    int lat;
  } exp_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input int ia, input int ib, input int iop);
    exp_t e;
    int mod1;
    int mod2;
    mod1  = 1 << W;
    mod2  = 1 << (2 * W);
    e.res = 0;
    e.c   = 0;
    e.e   = 0;
    e.lat = 1;
    case (iop)
      0: begin e.res = ia + ib; e.c = (ia + ib >= mod1) ? 1 : 0; end
      1: begin e.res = (ia - ib + mod1) % mod1; e.c = (ia < ib) ? 1 : 0; end
      2: e.res = ia & ib;
      3: e.res = ia | ib;
      4: e.res = ia ^ ib;
      5: e.res = (ib >= 2 * W) ? 0 : ((ia << ib) % mod2);
      6: e.res = (ib >= W) ? 0 : (ia >> ib);
      default: begin
        if (MUL_ON) begin
          e.res = ia * ib;
          e.lat = W + 1;
        end else begin
          e.res = 0;
          e.e   = 1;
        end
      end
    endcase
    e.z = (e.res == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/out_valid"}, 32'(out_valid), 0);
    check({tag, "/in_ready"},  32'(in_ready), 1);
    check({tag, "/result"},    32'(result), 0);
    check({tag, "/zero"},      32'(zero), 0);
    check({tag, "/carry"},     32'(carry), 0);
    check({tag, "/err"},       32'(err), 0);
  endtask

  // Starts at a falling edge with the DUT idle; ends at a falling edge, idle again.
  task automatic run_op(input int ia, input int ib, input int iop, input int hold, input string tag);
    exp_t e;
    int lat;
    e = model(ia, ib, iop);
    check({tag, "/idle_ready"}, 32'(in_ready), 1);
    a = W'(ia);
    b = W'(ib);
    op = 3'(iop);
    in_valid = 1'b1;
    @(posedge clk); #1;
    // keep offering a different operation; it must not be taken while busy
    a = W'(1);
    b = W'(1);
    op = 3'd0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      check({tag, "/busy_ready"}, 32'(in_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(e.lat));
    check({tag, "/result"},  32'(result), 32'(e.res));
    check({tag, "/zero"},    32'(zero), 32'(e.z));
    check({tag, "/carry"},   32'(carry), 32'(e.c));
    check({tag, "/err"},     32'(err), 32'(e.e));
    last_res   = int'(result);
    last_zero  = int'(zero);
    last_carry = int'(carry);
    last_err   = int'(err);
    last_lat   = lat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(out_valid), 1);
      check({tag, "/hold_ready"}, 32'(in_ready), 0);
      check({tag, "/hold_result"}, 32'(result), 32'(e.res));
      check({tag, "/hold_flags"}, {29'd0, zero, carry, err}, 32'((e.z << 2) | (e.c << 1) | e.e));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // in_valid was still high on the handoff edge: no accept may have happened
    check({tag, "/handoff_valid"}, 32'(out_valid), 0);
    check({tag, "/handoff_ready"}, 32'(in_ready), 1);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset release accepts
    run_op(5, 6, 0, 0, "add_5_6");
    check("add_5_6/spec_result", 32'(last_res), 11);
    check("add_5_6/spec_carry",  32'(last_carry), 1);
    check("add_5_6/spec_zero",   32'(last_zero), 0);
    check("add_5_6/spec_lat",    32'(last_lat), 1);

    run_op(2, 5, 1, 0, "sub_2_5");
    check("sub_2_5/spec_result", 32'(last_res), 5);
    check("sub_2_5/spec_carry",  32'(last_carry), 1);

    run_op(7, 7, 5, 0, "shl_7_7");
    check("shl_7_7/spec_result", 32'(last_res), 0);
    check("shl_7_7/spec_zero",   32'(last_zero), 1);

    run_op(7, 7, 7, 0, "mul_7_7");
    if (MUL_ON) begin
      check("mul_7_7/spec_result", 32'(last_res), 49);
      check("mul_7_7/spec_lat",    32'(last_lat), 4);
      check("mul_7_7/spec_err",    32'(last_err), 0);
    end else begin
      check("mul_7_7/spec_result", 32'(last_res), 0);
      check("mul_7_7/spec_lat",    32'(last_lat), 1);
      check("mul_7_7/spec_err",    32'(last_err), 1);
    end

    run_op(3, 4, 0, 5, "hold_done");
    run_op(6, 2, 6, 2, "shr_6_2");
    run_op(6, 3, 4, 1, "xor_6_3");

    // reset asserted two cycles into a multiply
    a = W'(7);
    b = W'(7);
    op = 3'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("abort_held");
    rst_n = 1'b1;
    run_op(1, 1, 0, 0, "post_reset_add");
    check("post_reset_add/spec_result", 32'(last_res), 2);

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand/opcode present.
REQ-005 SHALL have port in_ready  output  1  block accepts a new operation.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-007 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-008 SHALL have port op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  2*WIDTH  registered result.
REQ-012 SHALL have ports zero, carry, err  output  1 each  registered status flags.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept on in_valid & in_ready, latching a, b, op; later input changes are ignored until the next accept.
REQ-015 SHALL, for ops 0-6, move IDLE->DONE with result/flags valid the cycle after accept (latency 1).
REQ-016 SHALL, for MUL, move IDLE->MUL, iterate exactly WIDTH cycles, then enter DONE (latency WIDTH+1).
REQ-017 SHALL hold out_valid = 1 and result/flags stable throughout DONE; DONE->IDLE on out_ready = 1.
REQ-018 SHALL ignore in_valid in MUL and DONE; no same-cycle accept on the DONE->IDLE handoff.
REQ-019 SHALL compute ADD as zero-extended a+b; carry = sum bit WIDTH.
REQ-020 SHALL compute SUB as (a-b) mod 2^WIDTH, zero-extended; carry = borrow (a<b).
REQ-021 SHALL compute AND/OR/XOR bitwise, zero-extended; carry = 0.
REQ-022 SHALL compute SHL as (a<<b) truncated to 2*WIDTH bits, and SHR as a>>b; either yields 0 when the shift exceeds the width.
REQ-023 SHALL compute MUL as the full unsigned 2*WIDTH-bit product by shift-add; carry = 0.
REQ-024 SHALL set zero = (result == 0) and err = 0 for every op, except as given in REQ-029.

Reset
REQ-025 SHALL, while rst_n = 0, force state IDLE, result = 0, zero = carry = err = 0, out_valid = 0; in_ready reads 1.
REQ-026 SHALL abort any MUL or DONE in progress on reset assertion; no partial result survives.
REQ-027 SHALL accept an operation on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro ALU_SEQ_MUL_EN defined, implement MUL per REQ-016/023.
REQ-029 SHALL, without ALU_SEQ_MUL_EN, omit the multiplier; op 7 then takes latency 1 and returns result = 0, zero = 1, err = 1.

Structure
REQ-030 SHALL place the opcode enum (ADD..MUL) and state enum (IDLE, MUL, DONE) in shared package alu_pkg.
REQ-031 SHALL implement the iterative multiplier as sub-module alu_mul_seq (start, done, WIDTH-parametrised), instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH = 3)
REQ-032 SHALL check: ADD a=5 b=6 -> one cycle later out_valid=1, result=11, carry=1, zero=0.
REQ-033 SHALL check: SUB a=2 b=5 -> result=5, carry=1; SHL a=7 b=7 -> result=0, zero=1.
REQ-034 SHALL check: MUL a=7 b=7 -> with macro, result=49 after 4 cycles with in_ready=0 meanwhile; without it, result=0, err=1 after 1 cycle.
REQ-035 SHALL check: out_ready held 0 for 5 cycles in DONE -> result/flags/out_valid held, in_ready=0, new in_valid a=1 b=1 ignored.
REQ-036 SHALL check: rst_n pulsed low 2 cycles into MUL a=7 b=7 -> all outputs 0, in_ready=1; a following ADD a=1 b=1 -> result=2.
